// File: rtl/tessiax_fetch_pkg.sv
// -----------------------------------------------------------------------------
// tessiax_fetch_pkg
// Shared types and constants for the TessiaX fetch stage.
//   fetch_state_t : fetch controller state encoding (BOOT, FETCH, DRAIN, HOLD)
//   PC_INC        : sequential PC increment (one 32-bit instruction)
//   PC_OFS8       : PC+8 offset presented to decode
//   NOP_INSTR     : instruction word used for IF/ID bubbles
// Optional feature macro used by the stage: TESSIAX_FETCH_PERF_EN
// -----------------------------------------------------------------------------
package tessiax_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_INC    = 4;
    localparam int unsigned PC_OFS8   = 8;
    localparam int unsigned NOP_INSTR = 0;

endpackage

// File: rtl/if_id_register.sv
// -----------------------------------------------------------------------------
// if_id_register
// IF/ID pipeline register: instruction, instruction address + 8, valid flag.
// Update priority: reset > flush (bubble) > stall (hold) > load.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   i_flush                 write a bubble (wins over i_stall)
//   i_stall                 hold current contents
//   i_load                  capture i_instr / i_pc_plus8 / i_valid
//   i_instr, i_pc_plus8, i_valid   next IF/ID contents
//   o_instr, o_pc_plus8, o_valid   registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_register
    import tessiax_fetch_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_flush,
    input  logic               i_stall,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [WIDTH-1:0]   i_pc_plus8,
    input  logic               i_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [WIDTH-1:0]   o_pc_plus8,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [WIDTH-1:0]   r_pc_plus8;
    logic               r_valid;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_instr    <= INSTR_W'(NOP_INSTR);
            r_pc_plus8 <= '0;
            r_valid    <= 1'b0;
        end else if (!i_stall && i_load) begin
            r_instr    <= i_instr;
            r_pc_plus8 <= i_pc_plus8;
            r_valid    <= i_valid;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus8 = r_pc_plus8;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// TessiaX pipeline fetch stage: PC register, next-PC select (Execute branch
// redirect has priority over Writeback PC write), instruction-memory
// request/ready handshake, one-entry skid buffer and the IF/ID register.
// Optional performance counters are built when TESSIAX_FETCH_PERF_EN is
// defined; otherwise fetch_cnt / wait_cnt are tied to zero.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   StallD, FlushD                hazard unit hold / bubble for IF/ID (and PC)
//   BranchTakenE, ALUResultE      Execute redirect and target
//   PCSrcW, ResultW               Writeback redirect and target
//   imem_req, imem_addr           fetch request and address (= PCF)
//   imem_rdata, imem_ready        fetch response; completes on req & ready
//   PCF                           current fetch PC
//   InstructionD, PCPlus8D, ValidD  IF/ID outputs to decode
//   fetch_cnt, wait_cnt           completed fetches / wait cycles (optional)
// -----------------------------------------------------------------------------
module fetch_stage
    import tessiax_fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               BranchTakenE,
    input  logic [WIDTH-1:0]   ALUResultE,
    input  logic               PCSrcW,
    input  logic [WIDTH-1:0]   ResultW,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [WIDTH-1:0]   PCF,
    output logic [INSTR_W-1:0] InstructionD,
    output logic [WIDTH-1:0]   PCPlus8D,
    output logic               ValidD,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        wait_cnt
);

    fetch_state_t       r_state;
    logic [WIDTH-1:0]   r_pcf;
    logic               r_imem_req;
    logic [WIDTH-1:0]   r_pending;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [WIDTH-1:0]   r_skid_pc8;

    logic               w_redirect;
    logic [WIDTH-1:0]   w_target;
    logic [WIDTH-1:0]   w_pc_plus4;
    logic [WIDTH-1:0]   w_pc_plus8;
    logic               w_fire;

    logic               w_ifid_load;
    logic [INSTR_W-1:0] w_ifid_instr;
    logic [WIDTH-1:0]   w_ifid_pc8;
    logic               w_ifid_valid;

    assign w_redirect = BranchTakenE | PCSrcW;
    assign w_target   = BranchTakenE ? ALUResultE : ResultW;
    // Plain WIDTH-bit adds: the PC wraps silently at 2^WIDTH.
    assign w_pc_plus4 = r_pcf + WIDTH'(PC_INC);
    assign w_pc_plus8 = r_pcf + WIDTH'(PC_OFS8);
    assign w_fire     = r_imem_req & imem_ready;

    // ---------------------------------------------------------------------
    // Fetch controller. imem_req is registered and follows the next state
    // (high in FETCH and DRAIN), so it is stable for the whole cycle.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= BOOT;
            r_pcf        <= RESET_PC;
            r_imem_req   <= 1'b0;
            r_pending    <= '0;
            r_skid_instr <= INSTR_W'(NOP_INSTR);
            r_skid_pc8   <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= FETCH;
                    r_imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        if (w_redirect) begin
                            r_pcf <= w_target;
                        end else begin
                            r_pcf <= w_pc_plus4;
                            if (StallD) begin
                                // Decode cannot take it: park it in the skid
                                // buffer and stop requesting.
                                r_skid_instr <= imem_rdata;
                                r_skid_pc8   <= w_pc_plus8;
                                r_state      <= HOLD;
                                r_imem_req   <= 1'b0;
                            end
                        end
                    end else if (w_redirect) begin
                        // The request at the old PC must still complete
                        // before the address may change.
                        r_pending <= w_target;
                        r_state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        r_pcf   <= w_redirect ? w_target : r_pending;
                        r_state <= FETCH;
                    end else if (w_redirect) begin
                        r_pending <= w_target;
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_skid_instr <= INSTR_W'(NOP_INSTR);
                        r_skid_pc8   <= '0;
                        r_pcf        <= w_target;
                        r_state      <= FETCH;
                        r_imem_req   <= 1'b1;
                    end else if (!StallD) begin
                        r_skid_instr <= INSTR_W'(NOP_INSTR);
                        r_skid_pc8   <= '0;
                        r_state      <= FETCH;
                        r_imem_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= BOOT;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // IF/ID load selection. Whenever decode is not stalled and no real
    // instruction is available, a bubble is written so stale contents are
    // never decoded twice. A redirect out of HOLD leaves IF/ID untouched.
    // ---------------------------------------------------------------------
    always_comb begin
        w_ifid_load  = 1'b0;
        w_ifid_instr = INSTR_W'(NOP_INSTR);
        w_ifid_pc8   = '0;
        w_ifid_valid = 1'b0;
        case (r_state)
            FETCH: begin
                if (!StallD) begin
                    w_ifid_load = 1'b1;
                    if (imem_ready && !w_redirect) begin
                        w_ifid_instr = imem_rdata;
                        w_ifid_pc8   = w_pc_plus8;
                        w_ifid_valid = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!w_redirect && !StallD) begin
                    w_ifid_load  = 1'b1;
                    w_ifid_instr = r_skid_instr;
                    w_ifid_pc8   = r_skid_pc8;
                    w_ifid_valid = 1'b1;
                end
            end
            default: begin
                // BOOT and DRAIN: bubble when decode advances.
                w_ifid_load = !StallD;
            end
        endcase
    end

    if_id_register #(
        .WIDTH   (WIDTH),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (FlushD),
        .i_stall    (StallD),
        .i_load     (w_ifid_load),
        .i_instr    (w_ifid_instr),
        .i_pc_plus8 (w_ifid_pc8),
        .i_valid    (w_ifid_valid),
        .o_instr    (InstructionD),
        .o_pc_plus8 (PCPlus8D),
        .o_valid    (ValidD)
    );

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pcf;
    assign PCF       = r_pcf;

`ifdef TESSIAX_FETCH_PERF_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_wait_cnt;

    // Saturating counters; discarded responses still count as fetches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            if (w_fire && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (r_imem_req && !imem_ready && (r_wait_cnt != 16'hFFFF)) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign wait_cnt  = r_wait_cnt;
`else
    assign fetch_cnt = 16'd0;
    assign wait_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The instruction memory returns
// addr ^ 32'hE1000000 while ready, so every expected word below is a
// hand-computed constant. A second instance with RESET_PC = 0xFFFFFFFC
// covers PC wrap. Counter expectations depend on TESSIAX_FETCH_PERF_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, reset2;
    logic        StallD, FlushD, BranchTakenE, PCSrcW, imem_ready;
    logic [31:0] ALUResultE, ResultW;

    logic        imem_req, ValidD;
    logic [31:0] imem_addr, imem_rdata, PCF, InstructionD, PCPlus8D;
    logic [15:0] fetch_cnt, wait_cnt;

    logic        imem_req_2, ValidD_2;
    logic [31:0] imem_addr_2, imem_rdata_2, PCF_2, InstructionD_2, PCPlus8D_2;
    logic [15:0] fetch_cnt_2, wait_cnt_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata   = imem_ready ? (imem_addr   ^ 32'hE100_0000) : 32'hDEAD_BEEF;
    assign imem_rdata_2 = imem_ready ? (imem_addr_2 ^ 32'hE100_0000) : 32'hDEAD_BEEF;

    fetch_stage #(.WIDTH(32), .INSTR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .PCF(PCF), .InstructionD(InstructionD), .PCPlus8D(PCPlus8D),
        .ValidD(ValidD), .fetch_cnt(fetch_cnt), .wait_cnt(wait_cnt)
    );

    fetch_stage #(.WIDTH(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset2), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .imem_req(imem_req_2), .imem_addr(imem_addr_2),
        .imem_rdata(imem_rdata_2), .imem_ready(imem_ready),
        .PCF(PCF_2), .InstructionD(InstructionD_2), .PCPlus8D(PCPlus8D_2),
        .ValidD(ValidD_2), .fetch_cnt(fetch_cnt_2), .wait_cnt(wait_cnt_2)
    );

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t PCF=%h req=%b ID=%h P8=%h V=%b", $time, PCF, imem_req,
                 InstructionD, PCPlus8D, ValidD);
    endtask

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1;
        StallD = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0; PCSrcW = 1'b0;
        ALUResultE = '0; ResultW = '0; imem_ready = 1'b1;
        tick(); tick(); tick();
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got %h exp %h", PCF, 32'h0); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
        checks++; if ({ValidD, InstructionD, PCPlus8D} !== 65'h0) begin errors++; $display("FAIL reset_ifid got %b %h %h exp 0", ValidD, InstructionD, PCPlus8D); end
        checks++; if ({fetch_cnt, wait_cnt} !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h %h exp 0", fetch_cnt, wait_cnt); end
        checks++; if (PCF_2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pcf_wrap got %h exp fffffffc", PCF_2); end
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        tick();   // BOOT -> FETCH
        checks++; if (imem_req !== 1'b1 || PCF !== 32'h0 || ValidD !== 1'b0) begin errors++; $display("FAIL boot got req=%b pcf=%h v=%b exp 1 0 0", imem_req, PCF, ValidD); end
        tick();
        checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL seq_pcf1 got %h exp 4", PCF); end
        checks++; if (InstructionD !== 32'hE100_0000 || PCPlus8D !== 32'h8 || ValidD !== 1'b1) begin errors++; $display("FAIL seq_id0 got %h %h %b exp e1000000 8 1", InstructionD, PCPlus8D, ValidD); end
        tick();
        checks++; if (PCF !== 32'h8 || InstructionD !== 32'hE100_0004 || PCPlus8D !== 32'hC || ValidD !== 1'b1) begin errors++; $display("FAIL seq_id1 got %h %h %h %b exp 8 e1000004 c 1", PCF, InstructionD, PCPlus8D, ValidD); end
    endtask

    task automatic test_wait();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_addr !== 32'h8 || ValidD !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL wait_%0d got addr=%h v=%b req=%b exp 8 0 1", i, imem_addr, ValidD, imem_req); end
        end
`ifdef TESSIAX_FETCH_PERF_EN
        checks++; if (wait_cnt !== 16'd3) begin errors++; $display("FAIL wait_cnt got %0d exp 3", wait_cnt); end
`else
        checks++; if (wait_cnt !== 16'd0) begin errors++; $display("FAIL wait_cnt got %0d exp 0", wait_cnt); end
`endif
        imem_ready = 1'b1;
        tick();
        checks++; if (InstructionD !== 32'hE100_0008 || PCPlus8D !== 32'h10 || ValidD !== 1'b1 || PCF !== 32'hC) begin errors++; $display("FAIL wait_done got %h %h %b pcf=%h exp e1000008 10 1 c", InstructionD, PCPlus8D, ValidD, PCF); end
    endtask

    task automatic test_branch_drain();
        tick();
        checks++; if (PCF !== 32'h10 || InstructionD !== 32'hE100_000C || PCPlus8D !== 32'h14) begin errors++; $display("FAIL pre_drain got %h %h %h exp 10 e100000c 14", PCF, InstructionD, PCPlus8D); end
        imem_ready = 1'b0; BranchTakenE = 1'b1; ALUResultE = 32'h40;
        tick();   // FETCH -> DRAIN with pending 0x40
        BranchTakenE = 1'b0; ALUResultE = 32'h0;
        checks++; if (PCF !== 32'h10 || imem_req !== 1'b1 || ValidD !== 1'b0) begin errors++; $display("FAIL drain_enter got pcf=%h req=%b v=%b exp 10 1 0", PCF, imem_req, ValidD); end
        tick();
        checks++; if (imem_addr !== 32'h10 || ValidD !== 1'b0) begin errors++; $display("FAIL drain_hold got addr=%h v=%b exp 10 0", imem_addr, ValidD); end
        imem_ready = 1'b1;
        tick();   // response from 0x10 discarded
        checks++; if (PCF !== 32'h40 || ValidD !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL drain_exit got pcf=%h v=%b req=%b exp 40 0 1", PCF, ValidD, imem_req); end
        tick();
        checks++; if (InstructionD !== 32'hE100_0040 || PCPlus8D !== 32'h48 || ValidD !== 1'b1 || PCF !== 32'h44) begin errors++; $display("FAIL branch_target got %h %h %b pcf=%h exp e1000040 48 1 44", InstructionD, PCPlus8D, ValidD, PCF); end
    endtask

    task automatic test_stall_hold();
        BranchTakenE = 1'b1; ALUResultE = 32'h1C;
        tick();
        BranchTakenE = 1'b0; ALUResultE = 32'h0;
        checks++; if (PCF !== 32'h1C) begin errors++; $display("FAIL redirect_ready got %h exp 1c", PCF); end
        tick();
        checks++; if (PCF !== 32'h20 || InstructionD !== 32'hE100_001C || PCPlus8D !== 32'h24) begin errors++; $display("FAIL pre_stall got %h %h %h exp 20 e100001c 24", PCF, InstructionD, PCPlus8D); end
        StallD = 1'b1;
        tick();   // fetch at 0x20 completes into the skid buffer
        checks++; if (imem_req !== 1'b0 || PCF !== 32'h24) begin errors++; $display("FAIL hold_enter got req=%b pcf=%h exp 0 24", imem_req, PCF); end
        checks++; if (InstructionD !== 32'hE100_001C || PCPlus8D !== 32'h24 || ValidD !== 1'b1) begin errors++; $display("FAIL hold_ifid got %h %h %b exp e100001c 24 1", InstructionD, PCPlus8D, ValidD); end
        tick();
        checks++; if (imem_req !== 1'b0 || InstructionD !== 32'hE100_001C) begin errors++; $display("FAIL hold_stay got req=%b id=%h exp 0 e100001c", imem_req, InstructionD); end
        StallD = 1'b0;
        tick();
        checks++; if (InstructionD !== 32'hE100_0020 || PCPlus8D !== 32'h28 || ValidD !== 1'b1 || PCF !== 32'h24 || imem_req !== 1'b1) begin errors++; $display("FAIL hold_release got %h %h %b pcf=%h req=%b exp e1000020 28 1 24 1", InstructionD, PCPlus8D, ValidD, PCF, imem_req); end
        tick();
        checks++; if (InstructionD !== 32'hE100_0024 || PCPlus8D !== 32'h2C || PCF !== 32'h28) begin errors++; $display("FAIL post_hold got %h %h pcf=%h exp e1000024 2c 28", InstructionD, PCPlus8D, PCF); end
`ifdef TESSIAX_FETCH_PERF_EN
        checks++; if (fetch_cnt !== 16'd10 || wait_cnt !== 16'd5) begin errors++; $display("FAIL perf_cnt got %0d %0d exp 10 5", fetch_cnt, wait_cnt); end
`else
        checks++; if (fetch_cnt !== 16'd0 || wait_cnt !== 16'd0) begin errors++; $display("FAIL perf_cnt got %0d %0d exp 0 0", fetch_cnt, wait_cnt); end
`endif
    endtask

    task automatic test_redirect_flush();
        BranchTakenE = 1'b1; ALUResultE = 32'h80; PCSrcW = 1'b1; ResultW = 32'h90;
        tick();
        BranchTakenE = 1'b0; ALUResultE = 32'h0; PCSrcW = 1'b0; ResultW = 32'h0;
        checks++; if (PCF !== 32'h80) begin errors++; $display("FAIL redirect_prio got %h exp 80", PCF); end
        tick();
        checks++; if (InstructionD !== 32'hE100_0080 || PCPlus8D !== 32'h88 || PCF !== 32'h84) begin errors++; $display("FAIL fetch_80 got %h %h pcf=%h exp e1000080 88 84", InstructionD, PCPlus8D, PCF); end
        FlushD = 1'b1; StallD = 1'b1;
        tick();
        FlushD = 1'b0; StallD = 1'b0;
        checks++; if (ValidD !== 1'b0 || InstructionD !== 32'h0 || PCPlus8D !== 32'h0) begin errors++; $display("FAIL flush_stall got %b %h %h exp 0 0 0", ValidD, InstructionD, PCPlus8D); end
        tick();
        checks++; if (InstructionD !== 32'hE100_0084 || PCPlus8D !== 32'h8C || ValidD !== 1'b1 || PCF !== 32'h88) begin errors++; $display("FAIL skid_after_flush got %h %h %b pcf=%h exp e1000084 8c 1 88", InstructionD, PCPlus8D, ValidD, PCF); end
        PCSrcW = 1'b1; ResultW = 32'h100;
        tick();
        PCSrcW = 1'b0; ResultW = 32'h0;
        checks++; if (PCF !== 32'h100) begin errors++; $display("FAIL pcsrcw_only got %h exp 100", PCF); end
    endtask

    task automatic test_wrap_and_reset();
        reset2 = 1'b0;
        tick();   // wrap instance leaves BOOT
        checks++; if (PCF_2 !== 32'hFFFF_FFFC || imem_req_2 !== 1'b1 || fetch_cnt_2 !== 16'd0 || wait_cnt_2 !== 16'd0) begin errors++; $display("FAIL wrap_boot got pcf=%h req=%b cnt=%0d/%0d exp fffffffc 1 0 0", PCF_2, imem_req_2, fetch_cnt_2, wait_cnt_2); end
        tick();
        checks++; if (PCF_2 !== 32'h0 || PCPlus8D_2 !== 32'h4 || InstructionD_2 !== 32'h1EFF_FFFC || ValidD_2 !== 1'b1) begin errors++; $display("FAIL wrap_first got pcf=%h p8=%h id=%h v=%b exp 0 4 1efffffc 1", PCF_2, PCPlus8D_2, InstructionD_2, ValidD_2); end
        tick();
        checks++; if (PCF_2 !== 32'h4 || InstructionD_2 !== 32'hE100_0000 || PCPlus8D_2 !== 32'h8) begin errors++; $display("FAIL wrap_second got pcf=%h id=%h p8=%h exp 4 e1000000 8", PCF_2, InstructionD_2, PCPlus8D_2); end
        StallD = 1'b1;
        tick();   // main instance enters HOLD
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL pre_reset_hold got req=%b exp 0", imem_req); end
        reset = 1'b1;
        tick();
        checks++; if (PCF !== 32'h0 || imem_req !== 1'b0 || ValidD !== 1'b0 || InstructionD !== 32'h0 || PCPlus8D !== 32'h0) begin errors++; $display("FAIL reset_in_hold got pcf=%h req=%b v=%b id=%h p8=%h exp all 0", PCF, imem_req, ValidD, InstructionD, PCPlus8D); end
        checks++; if (fetch_cnt !== 16'd0 || wait_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt_hold got %0d %0d exp 0 0", fetch_cnt, wait_cnt); end
        reset = 1'b0; StallD = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || ValidD !== 1'b0 || PCF !== 32'h0) begin errors++; $display("FAIL reboot got req=%b v=%b pcf=%h exp 1 0 0", imem_req, ValidD, PCF); end
        tick();
        checks++; if (ValidD !== 1'b1 || InstructionD !== 32'hE100_0000 || PCPlus8D !== 32'h8) begin errors++; $display("FAIL reboot_fetch got %b %h %h exp 1 e1000000 8", ValidD, InstructionD, PCPlus8D); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait();
        test_branch_drain();
        test_stall_hold();
        test_redirect_flush();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Pipeline fetch stage of the TessiaX core, directly upstream of the decode stage.
- Owns the PC register, the next-PC select (branch redirects from Execute and Writeback), the instruction-memory request/ready handshake, a one-entry skid buffer and the IF/ID pipeline register.
- Produces InstructionD and PCPlus8D for decode.

Parameters:
- WIDTH, 32, PC/address and result width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- StallD  in  1  hazard unit: hold IF/ID (StallF is the same signal).
- FlushD  in  1  hazard unit: bubble IF/ID.
- BranchTakenE  in  1  Execute-stage branch redirect.
- ALUResultE  in  WIDTH  Execute branch target.
- PCSrcW  in  1  Writeback PC write (e.g. load into R15).
- ResultW  in  WIDTH  Writeback target.
- imem_req  out  1  fetch request.
- imem_addr  out  WIDTH  fetch address (= PCF).
- imem_rdata  in  INSTR_W  instruction; valid only while imem_ready is high.
- imem_ready  in  1  fetch completes this cycle when imem_req and imem_ready are both high.
- PCF  out  WIDTH  current fetch PC.
- InstructionD  out  INSTR_W  IF/ID instruction.
- PCPlus8D  out  WIDTH  IF/ID instruction address + 8.
- ValidD  out  1  IF/ID holds a real instruction.
- fetch_cnt  out  16  completed fetches (optional feature).
- wait_cnt  out  16  cycles with imem_req high and imem_ready low (optional feature).

Behaviour:
- Reset:
  - PCF = RESET_PC.
  - InstructionD = 0, PCPlus8D = 0, ValidD = 0.
  - Skid buffer empty, pending target = 0, counters = 0.
  - State = BOOT; imem_req = 0.
- Redirect and target:
  - redirect = BranchTakenE | PCSrcW.
  - Target = ALUResultE if BranchTakenE (priority), else ResultW.
- imem_addr = PCF at all times. Address is held stable while a request is outstanding.
- PC arithmetic: PC+4 and PC+8 are modulo 2^WIDTH, so the PC wraps silently.
- States:
  - BOOT: imem_req = 0; next state is FETCH.
  - FETCH: imem_req = 1.
    - ready & !redirect & !StallD: IF/ID <= {rdata, PCF+8, 1}; PCF <= PCF+4.
    - ready & !redirect & StallD: skid buffer <= {rdata, PCF+8}; PCF <= PCF+4; next state HOLD.
    - ready & redirect: discard rdata; PCF <= target.
    - !ready & redirect: latch target as pending; next state DRAIN.
    - !ready & !redirect & !StallD: IF/ID <= bubble (0, 0, 0).
  - DRAIN: imem_req = 1 at the old address; rdata is discarded.
    - A new redirect overwrites the pending target.
    - On ready: PCF <= pending target (or the same-cycle target if redirect); next state FETCH.
    - While in DRAIN, IF/ID bubbles when !StallD.
  - HOLD: imem_req = 0.
    - redirect: empty the buffer (no write to IF/ID); PCF <= target; next state FETCH.
    - else !StallD: IF/ID <= buffer with ValidD = 1; empty the buffer; next state FETCH.
- IF/ID update priority: reset > FlushD (bubble, even with StallD high) > StallD (hold) > load as above.
- A fetch completing in the same cycle as FlushD is dropped. Redirect is asserted by the hazard logic in that case.
- Latency: instruction appears on InstructionD the cycle after imem_ready. With zero-wait memory, one instruction per cycle.
- reset mid-DRAIN or mid-HOLD: the outstanding response and the buffer are abandoned, and BOOT is re-entered. Memory must tolerate the request being dropped.

Optional Feature:
- Macro: TESSIAX_FETCH_PERF_EN.
- Defined:
  - fetch_cnt increments on every completed fetch (including discarded ones).
  - wait_cnt increments on every cycle with imem_req & !imem_ready.
  - Both are 16-bit, saturating at 16'hFFFF and cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package tessiax_fetch_pkg:
  - fetch_state_t enum {BOOT, FETCH, DRAIN, HOLD}.
  - PC_INC = 4, PC_OFS8 = 8.
  - NOP_INSTR = 0.
- Sub-module if_id_register: holds InstructionD/PCPlus8D/ValidD with reset, flush, stall and load controls. Parameterised by WIDTH and INSTR_W.

Test Plan:
- Zero-wait memory (imem_ready = 1); release reset → BOOT 1 cycle, then PCF = 0, 4, 8. InstructionD follows one cycle later; PCPlus8D = 8, 12, 16; ValidD = 1.
- imem_ready low for 3 cycles at PCF = 8 → imem_addr stays 8; ValidD = 0 for those cycles; wait_cnt = 3 (perf enabled); the instruction from 8 then appears with PCPlus8D = 16.
- BranchTakenE = 1, ALUResultE = 0x40 while waiting at PCF = 0x10 → DRAIN; response from 0x10 discarded; next request at 0x40; no ValidD for 0x10.
- StallD high as fetch at 0x20 completes → HOLD, imem_req = 0, IF/ID held; StallD low → InstructionD = rdata(0x20), PCF = 0x24.
- BranchTakenE and PCSrcW both set (ALUResultE = 0x80, ResultW = 0x90) → PCF = 0x80. FlushD with StallD → ValidD = 0, InstructionD = 0.
- RESET_PC = 0xFFFFFFFC → second fetch at 0x0 (wrap); PCPlus8D of first instruction = 0x4. Reset asserted in HOLD → all outputs zero next cycle, state BOOT.
